// File: rtl/prog_loader_if.sv
// Byte-stream handshake plus the Stage1 instruction-memory programming bus.
// The loader connects through master; the byte source / Stage1 side through slave.
interface prog_loader_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [7:0]            Byte_In;
    logic                  Byte_Valid;
    logic                  Byte_Ready;
    logic                  ProgMode;
    logic [ADDR_WIDTH-1:0] Addr_Prog;
    logic [DATA_WIDTH-1:0] Data_Prog;
    logic                  Pipeline_Enable;

    modport master (
        input  Byte_In, Byte_Valid,
        output Byte_Ready, ProgMode, Addr_Prog, Data_Prog, Pipeline_Enable
    );

    modport slave (
        output Byte_In, Byte_Valid,
        input  Byte_Ready, ProgMode, Addr_Prog, Data_Prog, Pipeline_Enable
    );
endinterface

// File: rtl/prog_loader.sv
// Instruction-memory loader: assembles big-endian words from a byte stream and
// writes them to consecutive Stage1 addresses while the pipeline is held off.
module prog_loader #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start,
    input  logic [ADDR_WIDTH:0]   Word_Count,
    prog_loader_if.master         prog,
    output logic                  Busy,
    output logic                  Done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [ADDR_WIDTH:0] MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [1:0]          LAST_BYTE = 2'(DATA_WIDTH / 8 - 1);

    function automatic logic [ADDR_WIDTH:0] sat_count(input logic [ADDR_WIDTH:0] n);
        if (n > MAX_WORDS)
            return MAX_WORDS;
        return n;
    endfunction

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH:0]    count_q, count_d;
    logic [ADDR_WIDTH:0]    widx_q, widx_d, widx_inc;
    logic [1:0]             bidx_q, bidx_d;
    logic [DATA_WIDTH-9:0]  asm_q, asm_d;

    logic                   ready_d, mode_d, pe_d, busy_d, done_d;
    logic [ADDR_WIDTH-1:0]  addr_d;
    logic [DATA_WIDTH-1:0]  data_d;

    assign widx_inc = widx_q + (ADDR_WIDTH + 1)'(1);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        widx_d  = widx_q;
        bidx_d  = bidx_q;
        asm_d   = asm_q;
        ready_d = prog.Byte_Ready;
        mode_d  = prog.ProgMode;
        pe_d    = prog.Pipeline_Enable;
        addr_d  = prog.Addr_Prog;
        data_d  = prog.Data_Prog;
        busy_d  = Busy;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start) begin
                    busy_d = 1'b1;
                    if (Word_Count == '0) begin
                        state_d = FINISH;
                    end else begin
                        count_d = sat_count(Word_Count);
                        widx_d  = '0;
                        bidx_d  = '0;
                        addr_d  = '0;
                        data_d  = '0;
                        mode_d  = 1'b0;
                        pe_d    = 1'b0;
                        ready_d = 1'b1;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (prog.Byte_Valid) begin
                    asm_d  = {asm_q[DATA_WIDTH-17:0], prog.Byte_In};
                    bidx_d = bidx_q + 2'd1;
                    // Address/data move only on a complete word; Stage1 rewrites the held pair otherwise.
                    if (bidx_q == LAST_BYTE) begin
                        data_d  = {asm_q, prog.Byte_In};
                        addr_d  = widx_q[ADDR_WIDTH-1:0];
                        ready_d = 1'b0;
                        state_d = COMMIT;
                    end
                end
            end
            COMMIT: begin
                widx_d = widx_inc;
                if (widx_inc == count_q) begin
                    state_d = FINISH;
                end else begin
                    ready_d = 1'b1;
                    state_d = LOAD;
                end
            end
            FINISH: begin
                mode_d  = 1'b1;
                pe_d    = 1'b1;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q              <= IDLE;
            count_q              <= '0;
            widx_q               <= '0;
            bidx_q               <= '0;
            prog.Byte_Ready      <= 1'b0;
            prog.ProgMode        <= 1'b1;
            prog.Pipeline_Enable <= 1'b1;
            prog.Addr_Prog       <= '0;
            prog.Data_Prog       <= '0;
            Busy                 <= 1'b0;
            Done                 <= 1'b0;
        end else begin
            state_q              <= state_d;
            count_q              <= count_d;
            widx_q               <= widx_d;
            bidx_q               <= bidx_d;
            prog.Byte_Ready      <= ready_d;
            prog.ProgMode        <= mode_d;
            prog.Pipeline_Enable <= pe_d;
            prog.Addr_Prog       <= addr_d;
            prog.Data_Prog       <= data_d;
            Busy                 <= busy_d;
            Done                 <= done_d;
        end
    end

    // Partial-word assembly is pure datapath; stale contents are always overwritten before use.
    always_ff @(posedge clk) begin
        asm_q <= asm_d;
    end

endmodule
